// File: rtl/sasc_rx.sv
// Asynchronous serial receiver: 4x-oversampled start/data/stop framing into a single holding register.
// Define SASC_RX_PARITY_EN for 11-bit frames with an even parity bit; otherwise frames are 10 bits and par_err is 0.
module sasc_rx (
  input  logic       clk,
  input  logic       arst,
  input  logic       sio_ce_x4,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frm_err,
  output logic       ovr_err,
  output logic       par_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  state_t      state, state_n;
  logic        rxd_meta, rxd_s;
  logic [1:0]  ph;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        sample, start_ok, shift_en, frame_done;
  logic        par_calc;
`ifdef SASC_RX_PARITY_EN
  logic        par_bit;
  logic        par_smp;
`endif

  // Line synchronizer; resets to the idle-high level so reset never looks like a start bit
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sio_ce_x4 && !rxd_s) state_n = START;
      START:   if (sample) state_n = rxd_s ? IDLE : DATA;
      DATA:    if (sample && bit_cnt == 3'd7) begin
`ifdef SASC_RX_PARITY_EN
                 state_n = PARITY;
`else
                 state_n = STOP;
`endif
               end
`ifdef SASC_RX_PARITY_EN
      PARITY:  if (sample) state_n = STOP;
`endif
      STOP:    if (sample) state_n = rxd_s ? IDLE : WAIT_HI;
      WAIT_HI: if (sio_ce_x4 && rxd_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Sample points fall at ph==1: two strobes after start detect, i.e. mid-bit
  always_comb begin
    sample     = sio_ce_x4 && (ph == 2'd1) && (state != IDLE);
    start_ok   = sample && (state == START) && !rxd_s;
    shift_en   = sample && (state == DATA);
    frame_done = sample && (state == STOP);
`ifdef SASC_RX_PARITY_EN
    par_smp    = sample && (state == PARITY);
`endif
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ph      <= 2'd0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else if (sio_ce_x4) begin
      if (state == IDLE) ph <= 2'd0;
      else               ph <= ph + 2'd1;
      if (start_ok) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        shreg   <= {rxd_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

`ifdef SASC_RX_PARITY_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst)         par_bit <= 1'b0;
    else if (par_smp) par_bit <= rxd_s;
  end

  assign par_calc = ^{shreg, par_bit};
`else
  assign par_calc = 1'b0;
`endif

  // Holding register: a full register drops the new frame unless it is being read this cycle
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dout    <= 8'h00;
      valid   <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
      par_err <= 1'b0;
    end else if (frame_done && valid && !rd) begin
      ovr_err <= 1'b1;
    end else if (frame_done) begin
      dout    <= shreg;
      frm_err <= ~rxd_s;
      par_err <= par_calc;
      valid   <= 1'b1;
    end else if (rd && valid) begin
      valid   <= 1'b0;
      ovr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sasc_rx.sv
// Scoreboard bench for sasc_rx: stimulus pushes expected bytes, a monitor checks each new valid byte.
module tb_sasc_rx;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       sio_ce_x4 = 1'b0;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       valid, frm_err, ovr_err, par_err;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   ce_cnt = 0;

  sasc_rx dut (
    .clk       (clk),
    .arst      (arst),
    .sio_ce_x4 (sio_ce_x4),
    .rxd       (rxd),
    .rd        (rd),
    .dout      (dout),
    .valid     (valid),
    .frm_err   (frm_err),
    .ovr_err   (ovr_err),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  // 4x baud strobe: one clk in four
  initial begin
    forever begin
      @(negedge clk);
      ce_cnt = ce_cnt + 1;
      sio_ce_x4 = (ce_cnt % 4 == 0);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(16);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pb, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef SASC_RX_PARITY_EN
    send_bit(pb);
`endif
    send_bit(stp);
    rxd = 1'b1;
  endtask

  function automatic logic exp_par(input logic [7:0] b, input logic pb);
`ifdef SASC_RX_PARITY_EN
    return ^{b, pb};
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_exp(input logic [7:0] b, input logic f, input logic pb);
    exp_t e;
    e.d = b;
    e.f = f;
    e.p = exp_par(b, pb);
    q.push_back(e);
  endtask

  task automatic do_rd;
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  // Monitor: every rising edge of valid must match the oldest expected frame
  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (valid && !pv) begin
        if (q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_frame: got dout %h with nothing expected", dout);
        end else begin
          e = q.pop_front();
          chk("mon_dout", dout, e.d);
          chk("mon_frm_err", 8'(frm_err), 8'(e.f));
          chk("mon_par_err", 8'(par_err), 8'(e.p));
        end
      end
      pv = valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    chk("rst_dout", dout, 8'h00);
    chk("rst_valid", 8'(valid), 8'd0);
    chk("rst_frm_err", 8'(frm_err), 8'd0);
    chk("rst_ovr_err", 8'(ovr_err), 8'd0);
    chk("rst_par_err", 8'(par_err), 8'd0);
    arst = 1'b0;
    tick(10);

    // 0xA5 with good stop
    push_exp(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(8);
    chk("a5_valid", 8'(valid), 8'd1);
    chk("a5_ovr", 8'(ovr_err), 8'd0);
    do_rd;
    chk("a5_rd_valid", 8'(valid), 8'd0);
    chk("a5_dout_hold", dout, 8'hA5);

    // One-strobe glitch is a false start
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(200);
    chk("glitch_valid", 8'(valid), 8'd0);

    // Overrun: second frame dropped
    push_exp(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    tick(4);
    send_frame(8'h5A, 1'b0, 1'b1);
    tick(8);
    chk("ovr_valid", 8'(valid), 8'd1);
    chk("ovr_dout", dout, 8'h3C);
    chk("ovr_flag", 8'(ovr_err), 8'd1);
    do_rd;
    chk("ovr_rd_valid", 8'(valid), 8'd0);
    chk("ovr_rd_flag", 8'(ovr_err), 8'd0);

    // Break: one zero frame with framing error, then nothing until line returns high
    push_exp(8'h00, 1'b1, 1'b0);
    rxd = 1'b0;
    tick(480);
    chk("brk_valid", 8'(valid), 8'd1);
    chk("brk_frm", 8'(frm_err), 8'd1);
    chk("brk_ovr", 8'(ovr_err), 8'd0);
    rxd = 1'b1;
    tick(40);
    do_rd;
    tick(100);
    chk("brk_after_valid", 8'(valid), 8'd0);

    // Reset after 4th data bit of 0xFF, then 0x81
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    arst = 1'b1;
    tick(2);
    chk("mid_rst_valid", 8'(valid), 8'd0);
    chk("mid_rst_dout", dout, 8'h00);
    arst = 1'b0;
    tick(10);
    push_exp(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1);
    tick(8);
    chk("r81_ovr", 8'(ovr_err), 8'd0);
    chk("r81_dout", dout, 8'h81);
    do_rd;

`ifdef SASC_RX_PARITY_EN
    push_exp(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b0, 1'b1);
    tick(8);
    chk("par_bad", 8'(par_err), 8'd1);
    do_rd;
    push_exp(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    tick(8);
    chk("par_good", 8'(par_err), 8'd0);
    do_rd;
`endif

    tick(20);
    chk("queue_empty", 8'(q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
